// File: rtl/apb_arbiter_pkg.sv
// Shared AMBA APB bus widths and the arbiter FSM state encoding.
package apb_arbiter_pkg;

  localparam int P_ADDR_W = 32;
  localparam int P_DATA_W = 32;
  localparam int P_STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_arbiter.sv
// Two-master to one-slave APB arbiter: round-robin grant in IDLE,
// registered downstream request and an ACCESS-phase timeout.
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [P_ADDR_W-1:0] m0_paddr,
  input  logic                m0_psel,
  input  logic                m0_penable,
  input  logic                m0_pwrite,
  input  logic [P_DATA_W-1:0] m0_pwdata,
  input  logic [P_STRB_W-1:0] m0_pwstrb,
  output logic                m0_pready,
  output logic [P_DATA_W-1:0] m0_prdata,
  output logic                m0_pslverr,
  input  logic [P_ADDR_W-1:0] m1_paddr,
  input  logic                m1_psel,
  input  logic                m1_penable,
  input  logic                m1_pwrite,
  input  logic [P_DATA_W-1:0] m1_pwdata,
  input  logic [P_STRB_W-1:0] m1_pwstrb,
  output logic                m1_pready,
  output logic [P_DATA_W-1:0] m1_prdata,
  output logic                m1_pslverr,
  output logic [P_ADDR_W-1:0] s_paddr,
  output logic                s_psel,
  output logic                s_penable,
  output logic                s_pwrite,
  output logic [P_DATA_W-1:0] s_pwdata,
  output logic [P_STRB_W-1:0] s_pwstrb,
  input  logic                s_pready,
  input  logic [P_DATA_W-1:0] s_prdata,
  input  logic                s_pslverr
);

  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYC);

  apb_state_t            state_reg, state_next;
  logic                  ptr_reg;
  logic                  grant_reg;
  logic [7:0]            cnt_reg;
  logic [P_ADDR_W-1:0]   s_paddr_reg;
  logic                  s_pwrite_reg;
  logic [P_DATA_W-1:0]   s_pwdata_reg;
  logic [P_STRB_W-1:0]   s_pwstrb_reg;
  logic                  s_psel_reg;
  logic                  s_penable_reg;

  logic any_req;
  logic pick;
  logic xfer_done;
  logic xfer_tout;
  logic penable_unused;

  // Upstream penable carries no arbitration meaning; psel alone is the request.
  assign penable_unused = m0_penable ^ m1_penable;

  function automatic logic rr_pick(input logic req0, input logic req1, input logic ptr);
    if (req0 && req1) return ptr;
    else if (req1)    return 1'b1;
    else              return 1'b0;
  endfunction

  assign any_req   = m0_psel | m1_psel;
  assign pick      = rr_pick(m0_psel, m1_psel, ptr_reg);
  assign xfer_done = (state_reg == ST_ACCESS) && s_pready;
  // s_pready wins over a timeout landing in the same cycle.
  assign xfer_tout = (state_reg == ST_ACCESS) && !s_pready && (cnt_reg == TIMEOUT_VAL);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (any_req) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (xfer_done || xfer_tout) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= 1'b0;
      grant_reg     <= 1'b0;
      cnt_reg       <= 8'd0;
      s_paddr_reg   <= '0;
      s_pwrite_reg  <= 1'b0;
      s_pwdata_reg  <= '0;
      s_pwstrb_reg  <= '0;
      s_psel_reg    <= 1'b0;
      s_penable_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      s_psel_reg    <= (state_next != ST_IDLE);
      s_penable_reg <= (state_next == ST_ACCESS);
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            grant_reg    <= pick;
            ptr_reg      <= ~pick;
            cnt_reg      <= 8'd0;
            s_paddr_reg  <= pick ? m1_paddr  : m0_paddr;
            s_pwrite_reg <= pick ? m1_pwrite : m0_pwrite;
            s_pwdata_reg <= pick ? m1_pwdata : m0_pwdata;
            s_pwstrb_reg <= pick ? m1_pwstrb : m0_pwstrb;
          end
        end
        // cnt_reg holds the 1-based index of the current ACCESS cycle.
        ST_SETUP:  cnt_reg <= 8'd1;
        ST_ACCESS: if (!xfer_done && !xfer_tout) cnt_reg <= cnt_reg + 8'd1;
        default:   cnt_reg <= 8'd0;
      endcase
    end
  end

  assign s_paddr   = s_paddr_reg;
  assign s_pwrite  = s_pwrite_reg;
  assign s_pwdata  = s_pwdata_reg;
  assign s_pwstrb  = s_pwstrb_reg;
  assign s_psel    = s_psel_reg;
  assign s_penable = s_penable_reg;

  // A timeout returns zero data with an error flag to the granted master.
  assign m0_pready  = !grant_reg && (xfer_done || xfer_tout);
  assign m0_prdata  = (!grant_reg && xfer_done) ? s_prdata : '0;
  assign m0_pslverr = !grant_reg && (xfer_done ? s_pslverr : xfer_tout);
  assign m1_pready  = grant_reg && (xfer_done || xfer_tout);
  assign m1_prdata  = (grant_reg && xfer_done) ? s_prdata : '0;
  assign m1_pslverr = grant_reg && (xfer_done ? s_pslverr : xfer_tout);

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: single write, round-robin order, read
// with error, ACCESS timeout and asynchronous reset mid-transfer.
module tb_apb_arbiter;
  import apb_arbiter_pkg::*;

  logic                pclk;
  logic                preset;
  logic [P_ADDR_W-1:0] m0_paddr, m1_paddr;
  logic                m0_psel, m1_psel, m0_penable, m1_penable;
  logic                m0_pwrite, m1_pwrite;
  logic [P_DATA_W-1:0] m0_pwdata, m1_pwdata;
  logic [P_STRB_W-1:0] m0_pwstrb, m1_pwstrb;
  logic                m0_pready, m1_pready;
  logic [P_DATA_W-1:0] m0_prdata, m1_prdata;
  logic                m0_pslverr, m1_pslverr;
  logic [P_ADDR_W-1:0] s_paddr;
  logic                s_psel, s_penable, s_pwrite;
  logic [P_DATA_W-1:0] s_pwdata;
  logic [P_STRB_W-1:0] s_pwstrb;
  logic                s_pready;
  logic [P_DATA_W-1:0] s_prdata;
  logic                s_pslverr;

  int tests_run = 0;
  int fail_cnt  = 0;
  logic [1:0] rr_order [4];

  apb_arbiter #(.TIMEOUT_CYC(4)) dut (
    .pclk(pclk), .preset(preset),
    .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_pwdata(m0_pwdata), .m0_pwstrb(m0_pwstrb), .m0_pready(m0_pready), .m0_prdata(m0_prdata),
    .m0_pslverr(m0_pslverr),
    .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_pwdata(m1_pwdata), .m1_pwstrb(m1_pwstrb), .m1_pready(m1_pready), .m1_prdata(m1_prdata),
    .m1_pslverr(m1_pslverr),
    .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_pwdata(s_pwdata), .s_pwstrb(s_pwstrb), .s_pready(s_pready), .s_prdata(s_prdata),
    .s_pslverr(s_pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rr_order[0] = 2'd0; rr_order[1] = 2'd1; rr_order[2] = 2'd0; rr_order[3] = 2'd1;
    preset = 1'b1;
    m0_paddr = '0; m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_pwdata = '0; m0_pwstrb = '0;
    m1_paddr = '0; m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_pwdata = '0; m1_pwstrb = '0;
    s_pready = 1'b1; s_prdata = '0; s_pslverr = 1'b0;

    // Reset state
    #2;
    check("rst_s_psel", 32'(s_psel), 0);
    check("rst_s_penable", 32'(s_penable), 0);
    check("rst_s_paddr", s_paddr, 0);
    check("rst_m0_pready", 32'(m0_pready), 0);
    check("rst_m1_pready", 32'(m1_pready), 0);
    #10 preset = 1'b0;
    tick();

    // m0 single write, slave ready on first ACCESS cycle
    m0_psel = 1; m0_penable = 1; m0_paddr = 32'h1000; m0_pwrite = 1;
    m0_pwdata = 32'hDEADBEEF; m0_pwstrb = 4'hF;
    check("wr_pre_s_psel", 32'(s_psel), 0);
    tick();
    check("wr_e1_s_psel", 32'(s_psel), 1);
    check("wr_e1_s_penable", 32'(s_penable), 0);
    check("wr_e1_s_paddr", s_paddr, 32'h1000);
    check("wr_e1_s_pwdata", s_pwdata, 32'hDEADBEEF);
    check("wr_e1_s_pwstrb", 32'(s_pwstrb), 32'hF);
    check("wr_e1_s_pwrite", 32'(s_pwrite), 1);
    check("wr_e1_m0_pready", 32'(m0_pready), 0);
    m0_paddr = 32'h2222; m0_pwdata = 32'h0;
    tick();
    check("wr_e2_s_penable", 32'(s_penable), 1);
    check("wr_e2_s_paddr_held", s_paddr, 32'h1000);
    check("wr_e2_s_pwdata_held", s_pwdata, 32'hDEADBEEF);
    check("wr_e2_m0_pready", 32'(m0_pready), 1);
    check("wr_e2_m0_pslverr", 32'(m0_pslverr), 0);
    check("wr_e2_m1_pready", 32'(m1_pready), 0);
    check("wr_e2_m1_prdata", m1_prdata, 0);
    check("wr_e2_m1_pslverr", 32'(m1_pslverr), 0);
    m0_psel = 0; m0_penable = 0;
    tick();
    check("wr_e3_s_psel", 32'(s_psel), 0);
    check("wr_e3_m0_pready", 32'(m0_pready), 0);
    $display("[TB] m0 write 0x1000 done");

    // Round-robin from reset with both masters requesting continuously
    preset = 1'b1;
    #1 check("rr_rst_s_psel", 32'(s_psel), 0);
    #2 preset = 1'b0;
    m0_psel = 1; m0_paddr = 32'hA0; m0_pwrite = 1;
    m1_psel = 1; m1_paddr = 32'hB0; m1_pwrite = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_grant_addr", s_paddr, (rr_order[k] == 2'd0) ? 32'hA0 : 32'hB0);
      tick();
      check("rr_m0_pready", 32'(m0_pready), (rr_order[k] == 2'd0) ? 32'd1 : 32'd0);
      check("rr_m1_pready", 32'(m1_pready), (rr_order[k] == 2'd1) ? 32'd1 : 32'd0);
      if (k == 3) begin
        m0_psel = 0; m1_psel = 0;
      end
      tick();
      check("rr_idle_s_psel", 32'(s_psel), 0);
      $display("[TB] rr transfer %0d granted m%0d addr %h", k, rr_order[k], s_paddr);
    end

    // m1 read with slave error
    m1_psel = 1; m1_pwrite = 0; m1_paddr = 32'hC0;
    s_prdata = 32'h12345678; s_pslverr = 1;
    tick();
    check("rd_s_pwrite", 32'(s_pwrite), 0);
    check("rd_s_paddr", s_paddr, 32'hC0);
    tick();
    check("rd_m1_pready", 32'(m1_pready), 1);
    check("rd_m1_prdata", m1_prdata, 32'h12345678);
    check("rd_m1_pslverr", 32'(m1_pslverr), 1);
    check("rd_m0_prdata", m0_prdata, 0);
    check("rd_m0_pslverr", 32'(m0_pslverr), 0);
    m1_psel = 0;
    tick();
    check("rd_after_m1_prdata", m1_prdata, 0);
    check("rd_after_m1_pslverr", 32'(m1_pslverr), 0);
    check("rd_after_m1_pready", 32'(m1_pready), 0);
    s_pslverr = 0;
    $display("[TB] m1 read 0x12345678 with slverr done");

    // Timeout after 4 ACCESS cycles with slave never ready
    s_pready = 0;
    m0_psel = 1; m0_paddr = 32'h3000; m0_pwrite = 1;
    tick();
    tick();
    check("to_a1_m0_pready", 32'(m0_pready), 0);
    tick();
    tick();
    check("to_a3_m0_pready", 32'(m0_pready), 0);
    check("to_a3_s_penable", 32'(s_penable), 1);
    tick();
    check("to_a4_m0_pready", 32'(m0_pready), 1);
    check("to_a4_m0_pslverr", 32'(m0_pslverr), 1);
    check("to_a4_m0_prdata", m0_prdata, 0);
    check("to_a4_m1_pready", 32'(m1_pready), 0);
    m0_psel = 0;
    tick();
    check("to_after_s_psel", 32'(s_psel), 0);
    check("to_after_s_penable", 32'(s_penable), 0);
    check("to_after_m0_pready", 32'(m0_pready), 0);
    check("to_after_m0_pslverr", 32'(m0_pslverr), 0);
    $display("[TB] m0 timeout transfer done");

    // Asynchronous reset in the 2nd ACCESS cycle, then m1 alone
    m0_psel = 1; m0_paddr = 32'h5000; m0_pwdata = 32'h55AA55AA; m0_pwstrb = 4'h3;
    tick();
    tick();
    tick();
    check("ar_a2_s_penable", 32'(s_penable), 1);
    preset = 1'b1;
    #1;
    check("ar_s_psel", 32'(s_psel), 0);
    check("ar_s_penable", 32'(s_penable), 0);
    check("ar_s_paddr", s_paddr, 0);
    check("ar_s_pwdata", s_pwdata, 0);
    check("ar_s_pwstrb", 32'(s_pwstrb), 0);
    check("ar_s_pwrite", 32'(s_pwrite), 0);
    check("ar_m0_pready", 32'(m0_pready), 0);
    m0_psel = 0; s_pready = 1;
    #2 preset = 1'b0;
    tick();
    check("ar_no_replay_s_psel", 32'(s_psel), 0);
    m1_psel = 1; m1_paddr = 32'h4000; m1_pwrite = 1; m1_pwdata = 32'hCAFEF00D; m1_pwstrb = 4'hC;
    tick();
    check("ar_m1_s_psel", 32'(s_psel), 1);
    check("ar_m1_s_paddr", s_paddr, 32'h4000);
    check("ar_m1_s_pwdata", s_pwdata, 32'hCAFEF00D);
    check("ar_m1_s_pwstrb", 32'(s_pwstrb), 32'hC);
    tick();
    check("ar_m1_pready", 32'(m1_pready), 1);
    check("ar_m0_pready", 32'(m0_pready), 0);
    m1_psel = 0;
    tick();
    check("ar_end_s_psel", 32'(s_psel), 0);
    $display("[TB] reset abort and m1 write 0x4000 done");

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
